// File: rtl/mem_dir_pkg.sv
// Shared definitions for the home-memory directory/data storage block.
// Holds the home-state encodings, the init/run FSM state type and the
// derived-width helpers used by the top, the interface sizing and the bench.
package mem_dir_pkg;

    // Home-state field encodings (upper two bits of a directory entry)
    localparam logic [1:0] HS_R  = 2'b00;
    localparam logic [1:0] HS_W  = 2'b01;
    localparam logic [1:0] HS_TR = 2'b10;
    localparam logic [1:0] HS_TW = 2'b11;

    // Controller states: directory clear sweep, then normal service
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dir_fsm_e;

    // Byte-offset width inside one line
    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    // Line-index width for a home of the given depth
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // Directory entry width: two home-state bits plus the sharer vector
    function automatic int st_w(input int nodes);
        return nodes + 2;
    endfunction

endpackage

// File: rtl/memory_dir_data_ram_if.sv
// Request/response bundle between the home-directory controller (master)
// and the home storage block (slave).
//   req_*  : valid/ready request with state/data read and write controls
//   rsp_*  : registered response, rsp_valid pulses once per accepted request
interface memory_dir_data_ram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ST_W   = 6
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  req_state_we;
    logic                  req_state_re;
    logic [ST_W-1:0]       req_state;
    logic                  req_data_we;
    logic                  req_data_re;
    logic [DATA_W-1:0]     req_data;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [ST_W-1:0]       rsp_state;
    logic [DATA_W-1:0]     rsp_data;

    modport master (
        output req_valid, req_addr, req_state_we, req_state_re, req_state,
               req_data_we, req_data_re, req_data, req_be,
        input  req_ready, rsp_valid, rsp_err, rsp_state, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_state_we, req_state_re, req_state,
               req_data_we, req_data_re, req_data, req_be,
        output req_ready, rsp_valid, rsp_err, rsp_state, rsp_data
    );
endinterface

// File: rtl/dir_bram_1rw.sv
// Single-port synchronous RAM, read-first, with a per-lane write enable.
//   clk  : clock
//   en   : port enable (read and/or write this cycle)
//   we   : one write-enable bit per lane of WIDTH/BE_W bits
//   addr : entry index
//   din  : write data
//   dout : registered read data (contents before this cycle's write)
// The array carries no reset so it maps onto block RAM.
module dir_bram_1rw #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128,
    parameter int BE_W  = 1
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [BE_W-1:0]          we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);
    localparam int LANE_W = WIDTH / BE_W;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] dout_r;

    // Read old contents and update enabled lanes on the same edge
    always_ff @(posedge clk) begin
        if (en) begin
            dout_r <= mem_r[addr];
            for (int i = 0; i < BE_W; i++) begin
                if (we[i]) begin
                    mem_r[addr][i*LANE_W +: LANE_W] <= din[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign dout = dout_r;
endmodule

// File: rtl/memory_dir_data_ram.sv
// Home-memory storage for one ring node: a directory/state RAM and a
// line-data RAM sharing one line index, behind a valid/ready port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of memory_dir_data_ram_if (request + response)
//   init_done  : directory clear sweep finished (sticky until reset)
// Build option MEM_DIR_INIT_EN: when defined the block sweeps every
// directory entry to zero after reset before accepting requests; when
// undefined it starts serving at once and the controller owns initialisation.
// Response latency is one cycle after acceptance: the RAMs register the
// read on the accept edge and the response registers capture it one edge later.
module memory_dir_data_ram
    import mem_dir_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int DEPTH      = 128,
    parameter int NODES      = 4,
    parameter int HOME_BITS  = 2,
    parameter int HOME_ID    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    memory_dir_data_ram_if.slave  bus,
    output logic                  init_done
);
    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(DEPTH);
    localparam int ST_W   = st_w(NODES);
    localparam int DATA_W = 8 * LINE_BYTES;
    localparam int BE_W   = LINE_BYTES;
    localparam logic [HOME_BITS-1:0] HOME_V = HOME_BITS'(HOME_ID);

    dir_fsm_e          state_r;
    logic [IDX_W-1:0]  cnt_r;
    logic              ready_r;
    logic              init_done_r;

    logic              p_valid_r;
    logic              p_err_r;
    logic              p_sre_r;
    logic              p_dre_r;

    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [ST_W-1:0]   rsp_state_r;
    logic [DATA_W-1:0] rsp_data_r;

    logic              accept_s;
    logic              home_ok_s;
    logic [IDX_W-1:0]  idx_s;
    logic              st_en_s;
    logic [0:0]        st_we_s;
    logic [IDX_W-1:0]  st_addr_s;
    logic [ST_W-1:0]   st_din_s;
    logic [ST_W-1:0]   st_q_s;
    logic              dt_en_s;
    logic [BE_W-1:0]   dt_we_s;
    logic [DATA_W-1:0] dt_q_s;
    logic              addr_unused_s;

    assign accept_s  = bus.req_valid & ready_r;
    assign home_ok_s = (bus.req_addr[OFF_W+IDX_W +: HOME_BITS] == HOME_V);
    assign idx_s     = bus.req_addr[OFF_W +: IDX_W];
    // Byte offset and bits above the home field play no part in addressing
    assign addr_unused_s = ^{bus.req_addr[ADDR_W-1:OFF_W+IDX_W+HOME_BITS],
                             bus.req_addr[OFF_W-1:0]};

    // RAM port steering: the sweep owns the state RAM during INIT
    always_comb begin
        st_en_s   = 1'b0;
        st_we_s   = 1'b0;
        st_addr_s = idx_s;
        st_din_s  = bus.req_state;
        if (state_r == ST_INIT) begin
            st_en_s   = 1'b1;
            st_we_s   = 1'b1;
            st_addr_s = cnt_r;
            st_din_s  = {ST_W{1'b0}};
        end else begin
            st_en_s   = accept_s;
            st_we_s   = accept_s & home_ok_s & bus.req_state_we;
            st_addr_s = idx_s;
            st_din_s  = bus.req_state;
        end
        dt_en_s = accept_s;
        if (accept_s && home_ok_s && bus.req_data_we) begin
            dt_we_s = bus.req_be;
        end else begin
            dt_we_s = {BE_W{1'b0}};
        end
    end

    // Init sweep / run control with registered ready and init_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef MEM_DIR_INIT_EN
            state_r <= ST_INIT;
`else
            state_r <= ST_RUN;
`endif
            cnt_r       <= {IDX_W{1'b0}};
            ready_r     <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (cnt_r == IDX_W'(DEPTH - 1)) begin
                        state_r     <= ST_RUN;
                        ready_r     <= 1'b1;
                        init_done_r <= 1'b1;
                    end else begin
                        ready_r     <= 1'b0;
                        init_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    ready_r     <= 1'b1;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= {IDX_W{1'b0}};
                    ready_r     <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Response pipeline: remember request type on accept, emit next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_r   <= 1'b0;
            p_err_r     <= 1'b0;
            p_sre_r     <= 1'b0;
            p_dre_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_state_r <= {ST_W{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
        end else begin
            p_valid_r <= accept_s;
            if (accept_s) begin
                p_err_r <= ~home_ok_s;
                p_sre_r <= bus.req_state_re & home_ok_s;
                p_dre_r <= bus.req_data_re & home_ok_s;
            end
            rsp_valid_r <= p_valid_r;
            if (p_valid_r) begin
                rsp_err_r   <= p_err_r;
                rsp_state_r <= p_sre_r ? st_q_s : {ST_W{1'b0}};
                rsp_data_r  <= p_dre_r ? dt_q_s : {DATA_W{1'b0}};
            end
        end
    end

    dir_bram_1rw #(.WIDTH(ST_W), .DEPTH(DEPTH), .BE_W(1)) u_state_ram (
        .clk  (clk),
        .en   (st_en_s),
        .we   (st_we_s),
        .addr (st_addr_s),
        .din  (st_din_s),
        .dout (st_q_s)
    );

    dir_bram_1rw #(.WIDTH(DATA_W), .DEPTH(DEPTH), .BE_W(BE_W)) u_data_ram (
        .clk  (clk),
        .en   (dt_en_s),
        .we   (dt_we_s),
        .addr (idx_s),
        .din  (bus.req_data),
        .dout (dt_q_s)
    );

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_state = rsp_state_r;
    assign bus.rsp_data  = rsp_data_r;
    assign init_done     = init_done_r;
endmodule
